// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag/data widths, the empty-tag marker and a round-robin helper.
// Imported by every cdb_arbiter file; nothing here is redefined locally.
package cdb_arbiter_pkg;

  localparam int tagWidth  = 5;
  localparam int dataWidth = 32;

  // Tag value that means "no broadcast" (ROB has 16 entries, tags 0..15).
  localparam logic [tagWidth-1:0] emptyTag = 5'b10000;

  function automatic logic [1:0] rr_advance(input logic [1:0] idx, input int n);
    return (int'(idx) == n - 1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side bus of the CDB arbiter.
// Handshake: a source's result is taken on a clk edge where src_valid=1 and src_ready=1
// (and rdy=1, clear=0); src_ready does not depend on src_valid, and a refused producer holds its values.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3
) ();

  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC*tagWidth-1:0]  src_tag;
  logic [NUM_SRC*dataWidth-1:0] src_data;
  logic [NUM_SRC-1:0]           src_ready;
  logic [tagWidth-1:0]          cdb_tag;
  logic [dataWidth-1:0]         cdb_data;
  logic [1:0]                   cdb_src;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source holding buffer for (tag, data) results; DEPTH must be a power of two >= 2.
// The caller guarantees push only when not full and pop only when not empty.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [tagWidth-1:0]  push_tag,
  input  logic [dataWidth-1:0] push_data,
  output logic [tagWidth-1:0]  head_tag,
  output logic [dataWidth-1:0] head_data,
  output logic [CW-1:0]        count
);

  logic [tagWidth-1:0]  tag_mem  [DEPTH];
  logic [dataWidth-1:0] data_mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr]  <= push_tag;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: buffers results per source and broadcasts one per cycle.
// Optional statistics outputs grant_cnt/stall_cnt are built when CDB_STATS_EN is defined.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  cdb_arbiter_if.slave       bus,
  output logic [1:0]         dbg_rr_ptr
`ifdef CDB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0] grant_cnt,
  output logic [NUM_SRC*32-1:0] stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]        count     [NUM_SRC];
  logic [tagWidth-1:0]  head_tag  [NUM_SRC];
  logic [dataWidth-1:0] head_data [NUM_SRC];

  logic [NUM_SRC-1:0]   ready_vec;
  logic [NUM_SRC-1:0]   nonempty;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic                 flush;
  logic                 active;
  logic                 found;
  logic [1:0]           win;
  logic [tagWidth-1:0]  win_tag;
  logic [dataWidth-1:0] win_data;

  logic [1:0]           rr_ptr;
  logic [tagWidth-1:0]  cdb_tag_q;
  logic [dataWidth-1:0] cdb_data_q;
  logic [1:0]           cdb_src_q;

  assign flush  = rdy & clear;
  assign active = rdy & ~clear;

  always_comb begin
    ready_vec = '0;
    nonempty  = '0;
    push      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ready_vec[i] = (count[i] < CW'(FIFO_DEPTH));
      nonempty[i]  = (count[i] != '0);
      push[i]      = active & bus.src_valid[i] & ready_vec[i] &
                     (bus.src_tag[i*tagWidth +: tagWidth] != emptyTag);
    end
  end

  // Scan from rr_ptr; eligibility uses pre-edge buffer contents only.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && nonempty[i] && (((int'(rr_ptr) + off) % NUM_SRC) == i)) begin
          found = 1'b1;
          win   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    win_tag  = emptyTag;
    win_data = '0;
    pop      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win == 2'(i)) begin
        win_tag  = head_tag[i];
        win_data = head_data[i];
      end
      pop[i] = active & found & (win == 2'(i));
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_tag  (bus.src_tag[g*tagWidth +: tagWidth]),
      .push_data (bus.src_data[g*dataWidth +: dataWidth]),
      .head_tag  (head_tag[g]),
      .head_data (head_data[g]),
      .count     (count[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cdb_tag_q  <= emptyTag;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
    end else if (rdy) begin
      if (clear) begin
        rr_ptr     <= '0;
        cdb_tag_q  <= emptyTag;
        cdb_data_q <= '0;
        cdb_src_q  <= '0;
      end else if (found) begin
        rr_ptr     <= rr_advance(win, NUM_SRC);
        cdb_tag_q  <= win_tag;
        cdb_data_q <= win_data;
        cdb_src_q  <= win;
      end else begin
        cdb_tag_q  <= emptyTag;
        cdb_data_q <= '0;
        cdb_src_q  <= '0;
      end
    end
  end

  assign bus.src_ready = ready_vec;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
  assign dbg_rr_ptr    = rr_ptr;

`ifdef CDB_STATS_EN
  // Survive clear so flush storms remain visible; wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else if (rdy) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pop[i])
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
        if (bus.src_valid[i] && !ready_vec[i])
          stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 3, is the number of result producers sharing the broadcast bus (ALU, LSB, branch unit); legal range is 2..4.
REQ-002 Parameter FIFO_DEPTH, default 2, is the per-source holding-buffer depth; it SHALL be a power of two.
REQ-003 Reset is rst, synchronous, active-high; the clock is clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rdy  input  1  global enable; when low, all state and outputs SHALL hold.
REQ-007 clear  input  1  misprediction flush.
REQ-008 src_valid  input  NUM_SRC  per-source result-valid.
REQ-009 src_tag  input  NUM_SRC*tagWidth  per-source ROB tag, with source i at bits [i*tagWidth +: tagWidth].
REQ-010 src_data  input  NUM_SRC*dataWidth  per-source result data, packed the same way.
REQ-011 src_ready  output  NUM_SRC  per-source buffer-not-full flag (combinational from the buffer count).
REQ-012 cdb_tag  output  tagWidth  registered broadcast tag; emptyTag means no broadcast.
REQ-013 cdb_data  output  dataWidth  registered broadcast data.
REQ-014 cdb_src  output  2  index of the source that won the broadcast.

Function
REQ-015 A push into source i's buffer SHALL occur on a clk edge with rdy=1, clear=0, src_valid[i]=1, src_ready[i]=1 and src_tag[i]!=emptyTag.
REQ-016 A valid push carrying emptyTag SHALL be dropped silently.
REQ-017 src_ready[i] SHALL equal (count_i < FIFO_DEPTH); a pop in the same cycle SHALL NOT raise ready.
REQ-018 Arbitration eligibility SHALL use buffer contents before the edge, so a push at edge k can broadcast no earlier than edge k+1.
REQ-019 Arbitration SHALL be round-robin: scan begins at rr_ptr and the first non-empty buffer wins.
REQ-020 On each edge with rdy=1, the winner's head SHALL be popped and registered into cdb_tag, cdb_data and cdb_src.
REQ-021 After a grant, rr_ptr SHALL become (winner+1) mod NUM_SRC.
REQ-022 If no buffer is non-empty, cdb_tag SHALL be set to emptyTag, cdb_data to 0 and cdb_src to 0, and rr_ptr SHALL hold.
REQ-023 At most one broadcast SHALL occur per cycle.
REQ-024 Each buffer SHALL be FIFO-ordered; read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 A simultaneous push and pop on one buffer SHALL leave its count unchanged.
REQ-026 A full buffer SHALL refuse pushes and no entry SHALL be lost or duplicated.
REQ-027 clear=1 (with rdy=1) SHALL empty all buffers, drive cdb_tag to emptyTag, set rr_ptr to 0, and ignore same-cycle pushes.
REQ-028 With rdy=0, pushes and pops SHALL be suppressed and the outputs held.

Reset
REQ-029 rst SHALL take priority over rdy and clear.
REQ-030 On rst, all counts and pointers SHALL be 0, rr_ptr SHALL be 0, cdb_tag SHALL be emptyTag, cdb_data SHALL be 0, cdb_src SHALL be 0, and src_ready SHALL be all ones on the following cycle.
REQ-031 A reset mid-operation SHALL discard all buffered results.

Configuration
REQ-032 The macro CDB_STATS_EN SHALL control the statistics feature.
REQ-033 With CDB_STATS_EN defined, the module SHALL add output grant_cnt [NUM_SRC*32] (per-source broadcasts) and output stall_cnt [NUM_SRC*32] (cycles with src_valid=1 and src_ready=0).
REQ-034 The statistics counters SHALL clear on rst only (not on clear), count only when rdy=1, and wrap at 2^32.
REQ-035 Without CDB_STATS_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-036 tagWidth, dataWidth and emptyTag SHALL come from the shared defines package; no local redefinition is permitted.
REQ-037 A sub-module cdb_src_fifo (parameterised depth, tag+data, count output) SHALL be instantiated NUM_SRC times; the round-robin pick stays in cdb_arbiter.

Verification
REQ-038 After reset, a single push src0 tag=3 data=0x11 at edge 1 SHALL appear as cdb_tag=3, cdb_data=0x11, cdb_src=0 after edge 2, then cdb_tag=emptyTag.
REQ-039 With all three sources pushing tags 1/2/3 in the same cycle and rr_ptr=0, the broadcasts SHALL be 1, 2, 3 on consecutive cycles, with rr_ptr ending at 0.
REQ-040 With src1 held valid for 4 cycles while src0 is busy, src1_ready SHALL deassert after 2 accepted pushes; with CDB_STATS_EN, stall_cnt[1] SHALL count the refused cycles.
REQ-041 With both buffers full, asserting clear SHALL leave no broadcasts on following cycles, all src_ready high, and a new push tag=5 broadcast normally.
REQ-042 With rdy=0 for 3 cycles while src0 holds tag=4, cdb outputs SHALL hold and tag=4 SHALL broadcast on the first cycle with rdy=1.
REQ-043 A src2 push with tag=emptyTag and valid=1 SHALL produce no enqueue and no broadcast.
